code_counter: RTL and testbench
===============================

# code_counter

Dual-channel 64-bit event counter clocked from the system clock. One register counts every enabled cycle. The other counts every fourth enabled cycle via an internal prescaler. A select input steers each enabled cycle to one of the two channels. It sits as a leaf timing/statistics block, with both count registers exposed directly as outputs.

## Interface
Parameters:
- WIDTH, 64: width of both count outputs.
- DIV, 4: prescale ratio for channel 1; must be ≥ 2.
- Module name is `code_counter`.

Ports:
- Clk  input  1  system clock, rising-edge active.
- Reset  input  1  reset, asynchronous and active-low: Reset=0 clears all state immediately, independent of Clk.
- Slt  input  1  channel select: 0 = channel 0 (Output0), 1 = channel 1 (Output1).
- En  input  1  count enable; 0 freezes all state.
- Output0  output  WIDTH  channel 0 count, registered.
- Output1  output  WIDTH  channel 1 count, registered.

## Operation
- State:
  - Output0 register (WIDTH bits).
  - Output1 register (WIDTH bits).
  - Prescaler `pre`, ceil(log2(DIV)) bits, range 0..DIV-1.
- Reset=0: Output0=0, Output1=0, pre=0, held for as long as Reset=0.
- Reset=1 and En=0: all state holds.
- Reset=1, En=1, Slt=0:
  - Output0 ← Output0+1.
  - Output1 and pre hold; a partial prescale count is retained, not cleared.
- Reset=1, En=1, Slt=1, pre<DIV-1:
  - pre ← pre+1.
  - Output0 and Output1 hold.
- Reset=1, En=1, Slt=1, pre=DIV-1:
  - pre ← 0.
  - Output1 ← Output1+1.
  - Output0 holds.
- Arithmetic is unsigned, modulo 2^WIDTH:
  - All-ones + 1 wraps to 0.
  - No saturation and no overflow flag.
- The two channels never change in the same cycle.
- Changing Slt mid-count does not disturb either channel's accumulated value.

## Timing
- Slt and En are sampled on the rising edge of Clk. Outputs update on that same edge, with one-cycle latency from the sampled inputs.
- Channel 0: 1 increment per enabled cycle.
- Channel 1: first increment on the DIV-th enabled Slt=1 edge after reset (the 4th edge for DIV=4). Subsequent increments follow every DIV enabled Slt=1 edges, counted cumulatively across Slt=0 or En=0 gaps.
- Reset assertion takes effect asynchronously, mid-cycle. Outputs are 0 without waiting for a clock edge.
- Reset deassertion: the first counting edge is the first rising edge with Reset=1. Deassertion must meet recovery time relative to Clk; synchronizing Reset is outside this block.
- No combinational path from any input to Output0/Output1.

## Test plan
Defaults DIV=4, WIDTH=64, clock period 10 ns.
1. Reset=0 for 2 edges with En=1, Slt toggling -> Output0=0 and Output1=0 throughout. Pulse Reset=0 between edges while counts are nonzero -> both outputs become 0 before the next edge.
2. Reset=1, En=1, Slt=1 for 10 edges -> Output1 sequence 0,0,0,1,1,1,1,2,2,2; Output0=0; pre=2.
3. Continue from 2 with Slt=0 for 5 edges -> Output0=5, Output1=2. Then Slt=1 for 2 edges -> Output1=3 on the 2nd edge (retained pre=2 completes the group).
4. En=0 for 8 edges with Slt at either value -> Output0, Output1 and pre unchanged. Then En=1, Slt=0 for 1 edge -> Output0 increments by exactly 1.
5. Force Output0 to all-ones (via long run or a bench back-door), then 1 enabled Slt=0 edge -> Output0=0, Output1 unchanged. Repeat for Output1 with 4 Slt=1 edges -> Output1 wraps to 0.
6. Randomized En/Slt for 1000 edges against a reference model -> Output0 = number of edges with En=1 and Slt=0. Output1 = floor(number of edges with En=1 and Slt=1 / 4) since the last reset.

Source files
------------

// File: rtl/code_counter.sv
// Dual-channel event counter: channel 0 counts enabled cycles directly,
// channel 1 counts every DIV-th enabled cycle through a retained prescaler.
module code_counter #(
    parameter int WIDTH = 64,
    parameter int DIV   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Slt,
    input  logic             En,
    output logic [WIDTH-1:0] Output0,
    output logic [WIDTH-1:0] Output1
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic [WIDTH-1:0] r_out0;
    logic [WIDTH-1:0] r_out1;
    logic [PW-1:0]    r_pre;

    logic w_inc0;
    logic w_step;
    logic w_wrap;

    assign w_inc0 = En & ~Slt;
    assign w_step = En & Slt;
    assign w_wrap = (r_pre == PRE_MAX);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_out0 <= '0;
        end else if (w_inc0) begin
            r_out0 <= r_out0 + WIDTH'(1);
        end
    end

    // Partial prescale count survives Slt=0 and En=0 gaps.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pre  <= '0;
            r_out1 <= '0;
        end else if (w_step) begin
            if (w_wrap) begin
                r_pre  <= '0;
                r_out1 <= r_out1 + WIDTH'(1);
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    assign Output0 = r_out0;
    assign Output1 = r_out1;

endmodule

// File: tb/tb_code_counter.sv
// Scoreboard bench for code_counter: a 64-bit and a 4-bit instance share
// stimulus so the narrow one exercises wrap-around in reasonable time.
module tb_code_counter;

    typedef struct packed {
        logic [63:0] o0;
        logic [63:0] o1;
        logic [3:0]  s0;
        logic [3:0]  s1;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic        Slt;
    logic        En;
    logic [63:0] Output0;
    logic [63:0] Output1;
    logic [3:0]  sOut0;
    logic [3:0]  sOut1;

    int checks   = 0;
    int failures = 0;

    exp_t q[$];

    logic [63:0] m0;
    logic [63:0] m1;
    logic [3:0]  n0;
    logic [3:0]  n1;
    logic [1:0]  mpre;

    code_counter #(.WIDTH(64), .DIV(4)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Slt     (Slt),
        .En      (En),
        .Output0 (Output0),
        .Output1 (Output1)
    );

    code_counter #(.WIDTH(4), .DIV(4)) dut_s (
        .Clk     (Clk),
        .Reset   (Reset),
        .Slt     (Slt),
        .En      (En),
        .Output0 (sOut0),
        .Output1 (sOut1)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m0   = '0;
        m1   = '0;
        n0   = '0;
        n1   = '0;
        mpre = '0;
    endtask

    // Drive one cycle of inputs and queue the post-edge expectation.
    task automatic step(input logic rst, input logic en, input logic slt);
        exp_t e;
        @(negedge Clk);
        Reset = rst;
        En    = en;
        Slt   = slt;
        if (!rst) begin
            model_reset();
        end else if (en) begin
            if (!slt) begin
                m0 = m0 + 64'd1;
                n0 = n0 + 4'd1;
            end else if (mpre == 2'd3) begin
                mpre = 2'd0;
                m1 = m1 + 64'd1;
                n1 = n1 + 4'd1;
            end else begin
                mpre = mpre + 2'd1;
            end
        end
        e.o0 = m0;
        e.o1 = m1;
        e.s0 = n0;
        e.s1 = n1;
        q.push_back(e);
    endtask

    task automatic settle();
        @(posedge Clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out0", Output0, e.o0);
                chk("out1", Output1, e.o1);
                chk("s_out0", {60'd0, sOut0}, {60'd0, e.s0});
                chk("s_out1", {60'd0, sOut1}, {60'd0, e.s1});
            end
        end
    end

    initial begin : driver
        int k;
        Reset = 1'b0;
        En    = 1'b1;
        Slt   = 1'b0;
        model_reset();
        #1;
        chk("rst_out0", Output0, 64'd0);
        chk("rst_out1", Output1, 64'd0);

        // Reset held across edges with enable active
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);

        // Channel 1 prescaling: 10 Slt=1 edges
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1);
        settle();
        chk("t2_out0", Output0, 64'd0);
        chk("t2_out1", Output1, 64'd2);

        // Channel 0 run, then retained prescaler completes a group
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        settle();
        chk("t3_out0", Output0, 64'd5);
        chk("t3_out1", Output1, 64'd2);
        step(1'b1, 1'b1, 1'b1);
        settle();
        chk("t3_mid_out1", Output1, 64'd2);
        step(1'b1, 1'b1, 1'b1);
        settle();
        chk("t3_end_out1", Output1, 64'd3);

        // Enable low freezes everything, including the prescaler
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'(i & 1));
        step(1'b1, 1'b1, 1'b0);
        settle();
        chk("t4_out0", Output0, 64'd6);
        chk("t4_out1", Output1, 64'd3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        settle();
        chk("t4_pre_out1", Output1, 64'd3);
        step(1'b1, 1'b1, 1'b1);
        settle();
        chk("t4_grp_out1", Output1, 64'd4);

        // Asynchronous reset pulse between edges
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("async_out0", Output0, 64'd0);
        chk("async_out1", Output1, 64'd0);
        chk("async_s_out0", {60'd0, sOut0}, 64'd0);
        #1;
        Reset = 1'b1;
        En    = 1'b0;
        model_reset();

        // Wrap-around on the narrow instance
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0);
        settle();
        chk("w_s_out0_max", {60'd0, sOut0}, 64'd15);
        step(1'b1, 1'b1, 1'b0);
        settle();
        chk("w_s_out0_wrap", {60'd0, sOut0}, 64'd0);
        chk("w_s_out1_hold", {60'd0, sOut1}, 64'd0);
        chk("w_out0_wide", Output0, 64'd16);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 1'b1);
        settle();
        chk("w_s_out1_max", {60'd0, sOut1}, 64'd15);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1);
        settle();
        chk("w_s_out1_wrap", {60'd0, sOut1}, 64'd0);
        chk("w_out1_wide", Output1, 64'd16);

        // Random enable/select against the model
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end
        step(1'b1, 1'b0, 1'b0);

        k = 0;
        while (q.size() > 0 && k < 10) begin
            @(posedge Clk);
            k++;
        end
        #3;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
